// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//
// Purpose:
//   Hazard detection and operand forwarding for a classic 5-stage pipeline.
//   The unit keeps its own copy of the destination/control bits of the
//   instructions now in EX and MEM. From that copy it decides which bypass
//   path each ID source operand uses, and whether a load-use hazard needs a
//   one-cycle stall.
//
// Ports:
//   clk          in   1   pipeline clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   id_rs/id_rt  in   5   ID source registers A/B
//   id_use_rs/rt in   1   ID instruction really reads rs/rt
//   id_destR     in   5   ID destination register (already resolved)
//   id_wreg      in   1   ID instruction writes the register file
//   id_m2reg     in   1   ID instruction is a load
//   id_valid     in   1   ID slot holds a real instruction
//   flush        in   1   squash the ID instruction into a bubble
//   id_fwda/b    out  2   00 = regfile, 01 = mem_aluR (EX producer),
//                         10 = wb_dest (MEM producer)
//   stall        out  1   hold PC and IF/ID this cycle
//   bubble       out  1   zero the ID/EX control bits at the next edge
//   stall_count  out  16  saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_fwd_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_destR,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic        id_valid,
    input  logic        flush,
    output logic [1:0]  id_fwda,
    output logic [1:0]  id_fwdb,
    output logic        stall,
    output logic        bubble,
    output logic [15:0] stall_count
);

    // Tracking entries that mirror the instructions in EX and MEM.
    logic [4:0]  tex_dest_reg;
    logic        tex_wreg_reg;
    logic        tex_m2reg_reg;
    logic [4:0]  tmem_dest_reg;
    logic        tmem_wreg_reg;
    logic        tmem_m2reg_reg;
    logic [15:0] stall_count_reg;

    // Both source operands are handled the same way. Index 0 is rs and
    // index 1 is rt.
    logic [1:0][4:0] src;
    logic [1:0]      use_src;
    logic [1:0]      ex_hit;
    logic [1:0]      mem_hit;
    logic [1:0]      ex_load_hit;
    logic [1:0][1:0] fwd_sel;

    assign src     = {id_rt, id_rs};
    assign use_src = {id_use_rt, id_use_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // $0 is hard-wired, so an entry aimed at it never matches.
            assign ex_hit[gi]  = use_src[gi] & tex_wreg_reg &
                                 (tex_dest_reg != 5'd0) & (tex_dest_reg == src[gi]);
            assign mem_hit[gi] = use_src[gi] & tmem_wreg_reg &
                                 (tmem_dest_reg != 5'd0) & (tmem_dest_reg == src[gi]);
            // A load still in EX has no data yet, so it cannot be bypassed.
            assign ex_load_hit[gi] = ex_hit[gi] & tex_m2reg_reg;

            // EX is checked first so that the youngest producer wins.
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (ex_hit[gi]) begin
                    fwd_sel[gi] = 2'b01;
                end else if (mem_hit[gi]) begin
                    fwd_sel[gi] = 2'b10;
                end
            end
        end
    endgenerate

    assign id_fwda     = fwd_sel[0];
    assign id_fwdb     = fwd_sel[1];
    assign stall       = id_valid & (|ex_load_hit);
    assign bubble      = stall | flush | ~id_valid;
    assign stall_count = stall_count_reg;

    // A stalled cycle pushes a bubble into EX. On the next cycle the load
    // has moved to MEM, so the stall ends by itself after one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tex_dest_reg    <= 5'd0;
            tex_wreg_reg    <= 1'b0;
            tex_m2reg_reg   <= 1'b0;
            tmem_dest_reg   <= 5'd0;
            tmem_wreg_reg   <= 1'b0;
            tmem_m2reg_reg  <= 1'b0;
            stall_count_reg <= 16'd0;
        end else begin
            tmem_dest_reg  <= tex_dest_reg;
            tmem_wreg_reg  <= tex_wreg_reg;
            tmem_m2reg_reg <= tex_m2reg_reg;
            if (bubble) begin
                tex_dest_reg  <= 5'd0;
                tex_wreg_reg  <= 1'b0;
                tex_m2reg_reg <= 1'b0;
            end else begin
                tex_dest_reg  <= id_destR;
                tex_wreg_reg  <= id_wreg;
                tex_m2reg_reg <= id_m2reg;
            end
            if (stall && (stall_count_reg != 16'hFFFF)) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
        end
    end

    // The MEM load flag is kept so the entry stays a full copy of the
    // pipeline. Nothing downstream reads it, because a load in MEM is
    // simply forwarded.
    logic unused_ok;
    assign unused_ok = tmem_m2reg_reg;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
//   Directed instruction sequences for hazard_fwd_unit. Each step has
//   hand-computed expectations. A reference model tracks the last two
//   issued instructions as a small history, and a per-cycle compare process
//   checks the DUT against it.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_destR = 5'd0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic        id_wreg = 1'b0, id_m2reg = 1'b0, id_valid = 1'b0, flush = 1'b0;
    logic [1:0]  id_fwda, id_fwdb;
    logic        stall, bubble;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_fwd_unit dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_destR(id_destR), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_valid(id_valid), .flush(flush),
        .id_fwda(id_fwda), .id_fwdb(id_fwdb),
        .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[0] is the most recently issued instruction (now in EX).
    // hist[1] is the one issued before it (now in MEM).
    typedef struct {
        logic [4:0] dest;
        bit         wreg;
        bit         load;
    } ent_t;

    ent_t hist [2];
    int   m_count;

    function automatic int m_fwd(bit use_it, logic [4:0] s);
        if (!use_it || s == 5'd0) return 0;
        for (int age = 0; age < 2; age++) begin
            if (hist[age].wreg && hist[age].dest == s) return age + 1;
        end
        return 0;
    endfunction

    function automatic bit m_needs_load(bit use_it, logic [4:0] s);
        return use_it && s != 5'd0 && hist[0].wreg && hist[0].load && hist[0].dest == s;
    endfunction

    function automatic bit m_stall();
        return id_valid && (m_needs_load(id_use_rs, id_rs) || m_needs_load(id_use_rt, id_rt));
    endfunction

    function automatic bit m_bubble();
        return m_stall() || flush || !id_valid;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist[0] <= '{5'd0, 1'b0, 1'b0};
            hist[1] <= '{5'd0, 1'b0, 1'b0};
            m_count <= 0;
        end else begin
            hist[1] <= hist[0];
            if (m_bubble()) hist[0] <= '{5'd0, 1'b0, 1'b0};
            else            hist[0] <= '{id_destR, id_wreg, id_m2reg};
            if (m_stall() && m_count < 65535) m_count <= m_count + 1;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model. While stalled, the forward
    // selects do not matter to EX, so they are not compared.
    always @(negedge clk) begin
        chk("model.stall", int'(stall), int'(m_stall()));
        chk("model.bubble", int'(bubble), int'(m_bubble()));
        chk("model.stall_count", int'(stall_count), m_count);
        if (!m_stall()) begin
            chk("model.fwda", int'(id_fwda), m_fwd(id_use_rs, id_rs));
            chk("model.fwdb", int'(id_fwdb), m_fwd(id_use_rt, id_rt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit v, logic [4:0] rs, logic [4:0] rt, bit urs, bit urt,
                         logic [4:0] d, bit w, bit m, bit f);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_destR = d; id_wreg = w; id_m2reg = m; flush = f;
    endtask

    // One ID instruction for one cycle, checked against literal expectations.
    // An expectation of -1 means that value is not checked.
    task automatic step(string nm, bit v, logic [4:0] rs, logic [4:0] rt, bit urs, bit urt,
                        logic [4:0] d, bit w, bit m, bit f,
                        int efa, int efb, int est, int ebu);
        drive(v, rs, rt, urs, urt, d, w, m, f);
        @(negedge clk);
        if (efa >= 0) chk({nm, ".fwda"}, int'(id_fwda), efa);
        if (efb >= 0) chk({nm, ".fwdb"}, int'(id_fwdb), efb);
        if (est >= 0) chk({nm, ".stall"}, int'(stall), est);
        if (ebu >= 0) chk({nm, ".bubble"}, int'(bubble), ebu);
        $display("step %-12s fwda=%0d fwdb=%0d stall=%0d bubble=%0d count=%0d",
                 nm, id_fwda, id_fwdb, stall, bubble, stall_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state: empty entries, and an empty ID slot still bubbles.
        @(negedge clk);
        chk("reset.fwda", int'(id_fwda), 0);
        chk("reset.stall", int'(stall), 0);
        chk("reset.bubble", int'(bubble), 1);
        chk("reset.count", int'(stall_count), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        //      name          v  rs  rt  urs urt dest w  m  f   fa fb st bu
        step("add3",          1, 1,  2,  1,  1,  3,  1, 0, 0,  0, 0, 0, 0);
        step("sub4_3_5",      1, 3,  5,  1,  1,  4,  1, 0, 0,  1, 0, 0, 0);
        step("nop_a",         1, 0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 0, 0);
        step("add3_b",        1, 1,  2,  1,  1,  3,  1, 0, 0,  0, 0, 0, 0);
        step("nop_b",         1, 0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 0, 0);
        step("or6_1_3",       1, 1,  3,  1,  1,  6,  1, 0, 0,  0, 2, 0, 0);
        step("lw2",           1, 1,  2,  1,  0,  2,  1, 1, 0,  0, 0, 0, 0);
        step("add7_stall",    1, 2,  2,  1,  1,  7,  1, 0, 0, -1,-1, 1, 1);
        chk("loaduse.count_after", int'(stall_count), 1);
        step("add7_fwd",      1, 2,  2,  1,  1,  7,  1, 0, 0,  2, 2, 0, 0);
        step("add3_c",        1, 1,  2,  1,  1,  3,  1, 0, 0,  0, 0, 0, 0);
        step("addi3_3",       1, 3,  3,  1,  0,  3,  1, 0, 0,  1, 0, 0, 0);
        step("and8_3_1",      1, 3,  1,  1,  1,  8,  1, 0, 0,  1, 0, 0, 0);
        step("add0",          1, 1,  2,  1,  1,  0,  1, 0, 0,  0, 0, 0, 0);
        step("lw0",           1, 1,  0,  1,  0,  0,  1, 1, 0,  0, 0, 0, 0);
        step("add5_0_0",      1, 0,  0,  1,  1,  5,  1, 0, 0,  0, 0, 0, 0);
        step("nowrite9",      1, 1,  9,  1,  0,  9,  0, 0, 0,  0, 0, 0, 0);
        step("rd9_9",         1, 9,  9,  1,  1, 11,  1, 0, 0,  0, 0, 0, 0);
        step("lw4",           1, 1,  4,  1,  0,  4,  1, 1, 0,  0, 0, 0, 0);
        step("rd4_flush",     1, 4,  1,  1,  1, 12,  1, 0, 1, -1,-1, 1, 1);
        chk("flushstall.count", int'(stall_count), 2);
        step("rd4_fwd",       1, 4,  1,  1,  1, 12,  1, 0, 0,  2, 0, 0, 0);
        step("lw6",           1, 1,  6,  1,  0,  6,  1, 1, 0,  0, 0, 0, 0);

        // A load-use stall, then an asynchronous reset between edges.
        drive(1, 6, 1, 1, 1, 13, 1, 0, 0);
        @(negedge clk);
        chk("async.stall_before", int'(stall), 1);
        #2 rst = 1'b1;
        #1;
        chk("async.stall_in_rst", int'(stall), 0);
        chk("async.count_in_rst", int'(stall_count), 0);
        chk("async.bubble_in_rst", int'(bubble), 0);
        $display("step %-12s stall=%0d bubble=%0d count=%0d", "async_rst", stall, bubble, stall_count);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("async.stall_after", int'(stall), 0);
        chk("async.fwda_after", int'(id_fwda), 0);
        @(posedge clk);
        #1;
        // A flushed valid load must not reach T_EX, so the next reader neither stalls nor forwards.
        step("lw10_flush",    1, 1,  2,  1,  0, 10,  1, 1, 1,  0, 0, 0, 1);
        step("rd10",          1, 10, 10, 1,  1, 14,  1, 0, 0,  0, 0, 0, 0);
        chk("final.count", int'(stall_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be reset by rst, independent of clk.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 id_rs  input  5  source register A of the instruction in ID.
REQ-005 id_rt  input  5  source register B of the instruction in ID.
REQ-006 id_use_rs / id_use_rt  input  1 each  the ID instruction actually reads rs / rt.
REQ-007 id_destR  input  5  destination register of the ID instruction, already resolved from rt or rd.
REQ-008 id_wreg / id_m2reg  input  1 each  the ID instruction writes the register file / is a load.
REQ-009 id_valid  input  1  the ID slot holds a real instruction.
REQ-010 flush  input  1  squash the ID instruction; it enters EX as a bubble.
REQ-011 id_fwda / id_fwdb  output  2 each  forwarding selects travelling with the instruction into EX: 00 = register file, 01 = mem_aluR, 10 = wb_dest; 11 is never driven.
REQ-012 stall  output  1  hold PC and the IF/ID register this cycle.
REQ-013 bubble  output  1  force the ID/EX control bits (wreg, m2reg, wmem, branch) to 0 at the next edge.
REQ-014 stall_count  output  16  saturating count of stall cycles, for test.

Function
REQ-015 The block SHALL hold two tracking entries, T_EX and T_MEM, each {dest[4:0], wreg, m2reg}, mirroring the instructions in EX and MEM.
REQ-016 At each rising edge:
- T_MEM SHALL load T_EX.
- T_EX SHALL load {id_destR, id_wreg, id_m2reg} when bubble=0, else all-zero.
REQ-017 A tracking entry "matches" source s iff all three hold: the entry has wreg=1, dest != 0, and dest == s.
REQ-018 Forwarding for id_fwda SHALL be combinational: id_use_rs & T_EX matches id_rs -> 01; else id_use_rs & T_MEM matches id_rs -> 10; else 00. id_fwdb SHALL apply the same rule using id_use_rt and id_rt.
REQ-019 T_EX SHALL take priority over T_MEM when both match, so the most recent producer wins.
REQ-020 Load-use: stall SHALL be 1 iff id_valid=1, T_EX.m2reg=1, and T_EX matches id_rs (with id_use_rs) or id_rt (with id_use_rt).
REQ-021 Register 0 SHALL never produce a forward or a stall.
REQ-022 bubble SHALL equal stall | flush | ~id_valid.
REQ-023 A load-use stall SHALL last exactly one cycle. On the next cycle the load is in T_MEM, the ID instruction is unchanged and stall=0, and the operand SHALL be forwarded with 10.
REQ-024 While stall=1, the id_fwda/id_fwdb values SHALL be don't-care to EX, because bubble zeroes the EX controls.
REQ-025 flush and stall asserted together: flush wins for the EX entry (bubble=1); stall SHALL still be reported and stall_count SHALL still increment.
REQ-026 stall_count SHALL increment by 1 on every edge where stall=1 and SHALL saturate at 16'hFFFF with no wrap.
REQ-027 Producers three or more instructions ahead SHALL NOT be forwarded; the register file's write-before-read handles them, and this is out of scope for this block.
REQ-028 All outputs SHALL be functions only of the current inputs and T_EX/T_MEM; there SHALL be no further latency.

Reset
REQ-029 On rst=1: T_EX and T_MEM SHALL clear to all-zero and stall_count SHALL clear to 0, immediately, without waiting for clk.
REQ-030 During and after reset, with empty entries: id_fwda=id_fwdb=00 and stall=0; bubble SHALL follow REQ-022.
REQ-031 Reset asserted mid-stall SHALL cancel the stall: T_EX is cleared, so stall=0 while rst=1 and on the first cycle after rst deasserts.

Verification
REQ-032 Scenario: ADD $3 then SUB $4,$3,$5 back-to-back -> SUB in ID gets id_fwda=01, id_fwdb=00, stall=0.
REQ-033 Scenario: ADD $3, NOP, then OR $6,$1,$3 -> OR gets id_fwdb=10, id_fwda=00.
REQ-034 Scenario: LW $2 then ADD $7,$2,$2 -> stall=1 and bubble=1 for exactly one cycle, stall_count goes 0->1; the next cycle gives id_fwda=id_fwdb=10 and stall=0.
REQ-035 Scenario: ADD $3, ADDI $3, then AND $8,$3,$1 -> id_fwda=01 (T_EX priority, not 10).
REQ-036 Scenario: writes to $0, and a load to $0 followed by a read of $0 -> fwd=00 and stall=0; a destination of $9 with id_wreg=0 also gives no forward.
REQ-037 Scenario: rst pulsed asynchronously between edges during a load-use stall -> stall drops immediately and stall_count=0; after release, flush=1 with id_valid=1 inserts a bubble (T_EX empty on the next cycle).
